cnu_serial_min: RTL and testbench

CNU_SERIAL_MIN -- requirements
Module: cnu_serial_min

---
 rtl/cnu_pkg.sv | 13 +
 rtl/cnu_min2_insert.sv | 32 +++
 rtl/cnu_serial_min.sv | 114 +++++++++++
 tb/tb_cnu_serial_min.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cnu_pkg.sv
// rtl/cnu_pkg.sv - shared widths, magnitude constant and state encoding for the serial check-node unit
package cnu_pkg;
   localparam int CNU_DATA_W = 8;
   localparam int CNU_IDX_W  = 8;
   localparam int CNU_CNT_W  = 5;

   localparam logic [CNU_DATA_W-1:0] CNU_MAG_ONES = '1;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } cnu_state_e;
endpackage

// File: rtl/cnu_min2_insert.sv
// rtl/cnu_min2_insert.sv - combinational insert of one magnitude into a (min1, min2, idx) pair
module cnu_min2_insert
   import cnu_pkg::*;
#(
   parameter int DATA_W = CNU_DATA_W,
   parameter int IDX_W  = CNU_IDX_W
) (
   input  logic [DATA_W-1:0] min1,
   input  logic [DATA_W-1:0] min2,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] mag,
   input  logic [IDX_W-1:0]  in_idx,
   output logic [DATA_W-1:0] nxt_min1,
   output logic [DATA_W-1:0] nxt_min2,
   output logic [IDX_W-1:0]  nxt_idx
);

   // Strict compares: on a tie the earlier entry wins and stays in place.
   always_comb begin
      nxt_min1 = min1;
      nxt_min2 = min2;
      nxt_idx  = idx;
      if (mag < min1) begin
         nxt_min2 = min1;
         nxt_min1 = mag;
         nxt_idx  = in_idx;
      end else if (mag < min2) begin
         nxt_min2 = mag;
      end
   end

endmodule

// File: rtl/cnu_serial_min.sv
// rtl/cnu_serial_min.sv - serial min-sum check-node unit: accumulates a row of beats, then holds the result
module cnu_serial_min
   import cnu_pkg::*;
#(
   parameter int DATA_W = CNU_DATA_W,
   parameter int IDX_W  = CNU_IDX_W,
   parameter int CNT_W  = CNU_CNT_W,
   parameter int OFFSET = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_mag,
   input  logic                in_sign,
   input  logic [IDX_W-1:0]    in_idx,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2*DATA_W-1:0] out_min,
   output logic [IDX_W-1:0]    out_idx,
   output logic                out_sign,
   output logic [CNT_W-1:0]    out_cnt
);

   localparam logic [DATA_W-1:0] MAG_ONES = '1;
   localparam logic [DATA_W-1:0] OFF      = OFFSET[DATA_W-1:0];
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   cnu_state_e state, state_nxt;

   logic [DATA_W-1:0] min1_r, min2_r;
   logic [IDX_W-1:0]  idx_r;
   logic              sign_r;
   logic [CNT_W-1:0]  cnt_r;

   logic [DATA_W-1:0] ins_min1, ins_min2;
   logic [IDX_W-1:0]  ins_idx;

   logic accept;
   logic release_row;

   assign accept      = in_valid & in_ready;
   assign release_row = out_valid & out_ready;

   cnu_min2_insert #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_insert (
      .min1     (min1_r),
      .min2     (min2_r),
      .idx      (idx_r),
      .mag      (in_mag),
      .in_idx   (in_idx),
      .nxt_min1 (ins_min1),
      .nxt_min2 (ins_min2),
      .nxt_idx  (ins_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_ACCUM;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_ACCUM: begin
            in_ready = 1'b1;
            if (accept && in_last) state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ST_ACCUM;
         end
         default: state_nxt = ST_ACCUM;
      endcase
   end

   // Accumulators clear on the handshake edge so the next row starts clean.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         min1_r <= MAG_ONES;
         min2_r <= MAG_ONES;
         idx_r  <= '0;
         sign_r <= 1'b0;
         cnt_r  <= '0;
      end else if (release_row) begin
         min1_r <= MAG_ONES;
         min2_r <= MAG_ONES;
         idx_r  <= '0;
         sign_r <= 1'b0;
         cnt_r  <= '0;
      end else if (accept) begin
         min1_r <= ins_min1;
         min2_r <= ins_min2;
         idx_r  <= ins_idx;
         sign_r <= sign_r ^ in_sign;
         if (cnt_r != CNT_MAX) cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   function automatic logic [DATA_W-1:0] apply_offset(input logic [DATA_W-1:0] m);
      return (m > OFF) ? (m - OFF) : '0;
   endfunction

   assign out_min  = {apply_offset(min2_r), apply_offset(min1_r)};
   assign out_idx  = idx_r;
   assign out_sign = sign_r;
   assign out_cnt  = cnt_r;

endmodule

// File: tb/tb_cnu_serial_min.sv
// tb/tb_cnu_serial_min.sv - directed bench for cnu_serial_min with OFFSET 0 and OFFSET 2 instances
module tb_cnu_serial_min;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_mag;
   logic        in_sign;
   logic [7:0]  in_idx;
   logic        in_last;
   logic        out_ready;

   logic        in_ready0, out_valid0, out_sign0;
   logic [15:0] out_min0;
   logic [7:0]  out_idx0;
   logic [4:0]  out_cnt0;

   logic        in_ready2, out_valid2, out_sign2;
   logic [15:0] out_min2;
   logic [7:0]  out_idx2;
   logic [4:0]  out_cnt2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cnu_serial_min #(.DATA_W(8), .IDX_W(8), .CNT_W(5), .OFFSET(0)) u_dut0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready0), .in_mag(in_mag), .in_sign(in_sign),
      .in_idx(in_idx), .in_last(in_last),
      .out_valid(out_valid0), .out_ready(out_ready), .out_min(out_min0),
      .out_idx(out_idx0), .out_sign(out_sign0), .out_cnt(out_cnt0)
   );

   cnu_serial_min #(.DATA_W(8), .IDX_W(8), .CNT_W(5), .OFFSET(2)) u_dut2 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready2), .in_mag(in_mag), .in_sign(in_sign),
      .in_idx(in_idx), .in_last(in_last),
      .out_valid(out_valid2), .out_ready(out_ready), .out_min(out_min2),
      .out_idx(out_idx2), .out_sign(out_sign2), .out_cnt(out_cnt2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] sub2(input logic [7:0] v);
      return (v > 8'd2) ? v - 8'd2 : 8'd0;
   endfunction

   task automatic beat(input logic [7:0] mag, input logic sgn, input logic [7:0] idx, input logic last);
      in_valid = 1'b1;
      in_mag   = mag;
      in_sign  = sgn;
      in_idx   = idx;
      in_last  = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Sample the held result for both instances (no handshake).
   task automatic check_out(input string tag, input logic [7:0] m1, input logic [7:0] m2,
                            input logic [7:0] idx, input logic sgn, input logic [4:0] cnt);
      check({tag, ".valid0"}, 32'(out_valid0), 32'd1);
      check({tag, ".valid2"}, 32'(out_valid2), 32'd1);
      check({tag, ".ready0"}, 32'(in_ready0), 32'd0);
      check({tag, ".min0"},   32'(out_min0), 32'({m2, m1}));
      check({tag, ".min2"},   32'(out_min2), 32'({sub2(m2), sub2(m1)}));
      check({tag, ".idx0"},   32'(out_idx0), 32'(idx));
      check({tag, ".idx2"},   32'(out_idx2), 32'(idx));
      check({tag, ".sign0"},  32'(out_sign0), 32'(sgn));
      check({tag, ".sign2"},  32'(out_sign2), 32'(sgn));
      check({tag, ".cnt0"},   32'(out_cnt0), 32'(cnt));
      check({tag, ".cnt2"},   32'(out_cnt2), 32'(cnt));
   endtask

   task automatic expect_row(input string tag, input logic [7:0] m1, input logic [7:0] m2,
                             input logic [7:0] idx, input logic sgn, input logic [4:0] cnt);
      @(negedge clk);
      check_out(tag, m1, m2, idx, sgn, cnt);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check({tag, ".rel_valid"}, 32'(out_valid0), 32'd0);
      check({tag, ".rel_ready"}, 32'(in_ready0), 32'd1);
      check({tag, ".rel_cnt"},   32'(out_cnt0), 32'd0);
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".valid0"}, 32'(out_valid0), 32'd0);
      check({tag, ".ready0"}, 32'(in_ready0), 32'd1);
      check({tag, ".min0"},   32'(out_min0), 32'h0000_ffff);
      check({tag, ".min2"},   32'(out_min2), 32'h0000_fdfd);
      check({tag, ".idx0"},   32'(out_idx0), 32'd0);
      check({tag, ".sign0"},  32'(out_sign0), 32'd0);
      check({tag, ".cnt0"},   32'(out_cnt0), 32'd0);
      check({tag, ".ready2"}, 32'(in_ready2), 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_mag    = '0;
      in_sign   = 1'b0;
      in_idx    = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;

      repeat (2) @(negedge clk);
      check_idle("reset");
      @(posedge clk);
      #1 rst = 1'b0;

      // basic row: 9,3,7,5
      beat(8'd9, 1'b1, 8'd0, 1'b0);
      beat(8'd3, 1'b0, 8'd1, 1'b0);
      beat(8'd7, 1'b1, 8'd2, 1'b0);
      beat(8'd5, 1'b1, 8'd3, 1'b1);
      expect_row("basic", 8'd3, 8'd5, 8'd1, 1'b1, 5'd4);

      // ties keep the earlier beat
      beat(8'd4, 1'b0, 8'd10, 1'b0);
      beat(8'd4, 1'b0, 8'd11, 1'b0);
      beat(8'd6, 1'b0, 8'd12, 1'b1);
      expect_row("tie", 8'd4, 8'd4, 8'd10, 1'b0, 5'd3);

      // offset clamps at zero
      beat(8'd1, 1'b0, 8'd0, 1'b0);
      beat(8'd5, 1'b0, 8'd1, 1'b1);
      expect_row("offset", 8'd1, 8'd5, 8'd0, 1'b0, 5'd2);

      // single beat row leaves min2 at all-ones
      beat(8'd7, 1'b1, 8'd5, 1'b1);
      expect_row("single", 8'd7, 8'd255, 8'd5, 1'b1, 5'd1);

      // backpressure with ignored beats in HOLD
      beat(8'd20, 1'b0, 8'd1, 1'b0);
      beat(8'd30, 1'b1, 8'd2, 1'b1);
      in_valid = 1'b1;
      in_mag   = 8'd0;
      in_sign  = 1'b1;
      in_idx   = 8'd99;
      in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_out($sformatf("hold%0d", i), 8'd20, 8'd30, 8'd1, 1'b1, 5'd2);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_mag    = 8'd40;
      in_sign   = 1'b0;
      in_idx    = 8'd7;
      in_last   = 1'b0;
      @(negedge clk);
      check("after_hold.ready", 32'(in_ready0), 32'd1);
      check("after_hold.cnt",   32'(out_cnt0), 32'd0);
      check("after_hold.min",   32'(out_min0), 32'h0000_ffff);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      beat(8'd50, 1'b1, 8'd8, 1'b1);
      expect_row("next_row", 8'd40, 8'd50, 8'd7, 1'b1, 5'd2);

      // reset mid-row
      beat(8'd1, 1'b1, 8'd3, 1'b0);
      beat(8'd1, 1'b0, 8'd4, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check_idle("midrst");
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst.valid", 32'(out_valid0), 32'd0);
      beat(8'd8, 1'b0, 8'd0, 1'b0);
      beat(8'd2, 1'b0, 8'd1, 1'b1);
      expect_row("post_rst", 8'd2, 8'd8, 8'd1, 1'b0, 5'd2);

      // 40 beats: counter saturates at 31
      for (int i = 0; i < 40; i++) begin
         logic [7:0] m;
         m = (i == 17) ? 8'd3 : (i == 30) ? 8'd4 : 8'(100 + i);
         beat(m, (i < 5), 8'(i), (i == 39));
      end
      expect_row("sat", 8'd3, 8'd4, 8'd17, 1'b1, 5'd31);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
